// File: rtl/stats_reporter_if.sv
// Byte-stream link between stats_reporter and the UART: RX command bytes in, TX status bytes out.
// A TX byte transfers on a rising clk edge where tx_valid && tx_ready; once raised, tx_valid and
// tx_data hold steady until that transfer. rx_valid is a one-cycle strobe with no back-pressure.
interface stats_reporter_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/stats_reporter.sv
// Snapshots six pet stats and emits them as an ASCII frame "S" + 7 hex digits (+ checksum) + CR LF.
// Optional: define STATS_REPORT_CHECKSUM_EN to append the XOR of the payload as two hex digits.
module stats_reporter #(
  parameter logic [7:0] QUERY_BYTE  = 8'h3F,
  parameter logic [7:0] SOF_BYTE    = 8'h53,
  parameter bit         AUTO_REPORT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               second,
  input  logic [3:0]         hunger,
  input  logic [4:0]         happiness,
  input  logic [3:0]         health,
  input  logic [3:0]         hygiene,
  input  logic [3:0]         energy,
  input  logic [3:0]         social,
  stats_reporter_if.master   link,
  output logic               busy,
  output logic [7:0]         frames_sent,
  output logic               dbg_state
);

  typedef enum logic {IDLE, SEND} state_e;

`ifdef STATS_REPORT_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd11;
`else
  localparam logic [3:0] LAST_IDX = 4'd9;
`endif

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  logic       second_q;
  logic [7:0] frames_q, frames_d;
  logic [3:0] snap_hunger_q, snap_hunger_d;
  logic [4:0] snap_happy_q, snap_happy_d;
  logic [3:0] snap_health_q, snap_health_d;
  logic [3:0] snap_hygiene_q, snap_hygiene_d;
  logic [3:0] snap_energy_q, snap_energy_d;
  logic [3:0] snap_social_q, snap_social_d;

  logic       trig;
  logic       snap_load;
  logic [7:0] cur_byte;
  logic [7:0] payload [7];

  assign trig = (AUTO_REPORT && (second != second_q)) ||
                (link.rx_valid && (link.rx_data == QUERY_BYTE));

  assign payload[0] = hex(snap_hunger_q);
  assign payload[1] = hex({3'b000, snap_happy_q[4]});
  assign payload[2] = hex(snap_happy_q[3:0]);
  assign payload[3] = hex(snap_health_q);
  assign payload[4] = hex(snap_hygiene_q);
  assign payload[5] = hex(snap_energy_q);
  assign payload[6] = hex(snap_social_q);

`ifdef STATS_REPORT_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = payload[0] ^ payload[1] ^ payload[2] ^ payload[3] ^
                payload[4] ^ payload[5] ^ payload[6];
`endif

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0:    cur_byte = SOF_BYTE;
      4'd1:    cur_byte = payload[0];
      4'd2:    cur_byte = payload[1];
      4'd3:    cur_byte = payload[2];
      4'd4:    cur_byte = payload[3];
      4'd5:    cur_byte = payload[4];
      4'd6:    cur_byte = payload[5];
      4'd7:    cur_byte = payload[6];
`ifdef STATS_REPORT_CHECKSUM_EN
      4'd8:    cur_byte = hex(csum[7:4]);
      4'd9:    cur_byte = hex(csum[3:0]);
      4'd10:   cur_byte = 8'h0D;
      4'd11:   cur_byte = 8'h0A;
`else
      4'd8:    cur_byte = 8'h0D;
      4'd9:    cur_byte = 8'h0A;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  // A trigger landing on the last-byte handshake chains straight into a new frame.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    frames_d  = frames_q;
    snap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d   = SEND;
          idx_d     = 4'd0;
          snap_load = 1'b1;
        end
      end
      SEND: begin
        if (trig) pending_d = 1'b1;
        if (link.tx_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 4'd1;
          end else begin
            frames_d = frames_q + 8'd1;
            idx_d    = 4'd0;
            if (pending_q || trig) begin
              snap_load = 1'b1;
              pending_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snap_hunger_d  = snap_load ? hunger    : snap_hunger_q;
    snap_happy_d   = snap_load ? happiness : snap_happy_q;
    snap_health_d  = snap_load ? health    : snap_health_q;
    snap_hygiene_d = snap_load ? hygiene   : snap_hygiene_q;
    snap_energy_d  = snap_load ? energy    : snap_energy_q;
    snap_social_d  = snap_load ? social    : snap_social_q;
  end

  always_ff @(posedge clk) begin
    second_q <= second;
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      pending_q <= 1'b0;
      frames_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      frames_q  <= frames_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_hunger_q  <= snap_hunger_d;
    snap_happy_q   <= snap_happy_d;
    snap_health_q  <= snap_health_d;
    snap_hygiene_q <= snap_hygiene_d;
    snap_energy_q  <= snap_energy_d;
    snap_social_q  <= snap_social_d;
  end

  assign link.tx_valid = (state_q == SEND);
  assign link.tx_data  = (state_q == SEND) ? cur_byte : 8'h00;
  assign busy          = (state_q == SEND);
  assign frames_sent   = frames_q;
  assign dbg_state     = (state_q == SEND);

endmodule

// File: tb/tb_stats_reporter.sv
// Directed bench for stats_reporter: one DUT with periodic reports, one query-only DUT.
module tb_stats_reporter;

`ifdef STATS_REPORT_CHECKSUM_EN
  localparam int LEN = 12;
`else
  localparam int LEN = 10;
`endif

  logic       clk;
  logic       reset;
  logic       second;
  logic       second_b;
  logic [3:0] hunger, health, hygiene, energy, social;
  logic [4:0] happiness;
  logic       busy, busy_b, dbg_state, dbg_state_b;
  logic [7:0] frames_sent, frames_sent_b;

  stats_reporter_if bus();
  stats_reporter_if bus_b();

  stats_reporter dut (
    .clk(clk), .reset(reset), .second(second),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .social(social),
    .link(bus), .busy(busy), .frames_sent(frames_sent), .dbg_state(dbg_state)
  );

  stats_reporter #(.AUTO_REPORT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .second(second_b),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .social(social),
    .link(bus_b), .busy(busy_b), .frames_sent(frames_sent_b), .dbg_state(dbg_state_b)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard
  int         nvec  = 0;
  int         nmiss = 0;
  int         hs_cnt = 0;
  int         b_valid_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] b_got [$];
  logic [7:0] gold [12];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    return 8'h41 + {4'd0, n - 4'd10};
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    logic [7:0] p [7];
    logic [7:0] cs;
    p[0] = hx(hunger);   p[1] = hx({3'b000, happiness[4]}); p[2] = hx(happiness[3:0]);
    p[3] = hx(health);   p[4] = hx(hygiene); p[5] = hx(energy); p[6] = hx(social);
    cs = 8'h00;
    for (int k = 0; k < 7; k++) cs = cs ^ p[k];
    if (i == 0) return 8'h53;
    if (i >= 1 && i <= 7) return p[i-1];
    if (i == LEN - 2) return 8'h0D;
    if (i == LEN - 1) return 8'h0A;
    if (i == 8) return hx(cs[7:4]);
    return hx(cs[3:0]);
  endfunction

  always @(negedge clk) begin
    if (reset && prev_stall) begin
      check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
      check("hold_data", {24'd0, bus.tx_data}, {24'd0, prev_data});
    end
    if (reset && bus.tx_valid && bus.tx_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) check("unexpected_tx", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
      else check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
    end
    prev_stall = reset && bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
    if (reset && bus_b.tx_valid) begin
      b_valid_cnt++;
      if (bus_b.tx_ready) b_got.push_back(bus_b.tx_data);
    end
  end

  // ---------------- driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
  endtask

  task automatic send_rx_b(input logic [7:0] b);
    bus_b.rx_data = b; bus_b.rx_valid = 1'b1;
    tick(1);
    bus_b.rx_valid = 1'b0; bus_b.rx_data = 8'h00;
  endtask

  task automatic push_frame();
    for (int i = 0; i < LEN; i++) exp_q.push_back(exp_byte(i));
  endtask

  // ---------------- stimulus
  initial begin
    int stall;
    reset = 1'b0; second = 1'b0; second_b = 1'b0;
    hunger = 4'd3; happiness = 5'h12; health = 4'd10; hygiene = 4'd0; energy = 4'd15; social = 4'd7;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b1;
    bus_b.rx_data = 8'h00; bus_b.rx_valid = 1'b0; bus_b.tx_ready = 1'b1;
`ifdef STATS_REPORT_CHECKSUM_EN
    gold = '{8'h53, 8'h33, 8'h31, 8'h32, 8'h41, 8'h30, 8'h46, 8'h37, 8'h33, 8'h30, 8'h0D, 8'h0A};
`else
    gold = '{8'h53, 8'h33, 8'h31, 8'h32, 8'h41, 8'h30, 8'h46, 8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00};
`endif
    tick(3);
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frames", {24'd0, frames_sent}, 32'd0);
    reset = 1'b1;
    tick(3);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    // single query, literal golden stream
    for (int i = 0; i < LEN; i++) exp_q.push_back(gold[i]);
    send_rx(8'h3F);
    check("q_first_valid", {31'd0, bus.tx_valid}, 32'd1);
    check("q_first_sof", {24'd0, bus.tx_data}, 32'h53);
    for (int c = 0; c < LEN; c++) begin
      check("q_busy", {31'd0, busy}, 32'd1);
      tick(1);
    end
    check("q_done_idle", {31'd0, busy}, 32'd0);
    check("q_frames", {24'd0, frames_sent}, 32'd1);
    check("q_drained", exp_q.size(), 32'd0);

    // backpressure with a long stall on byte 4
    hs_cnt = 0; stall = 0;
    bus.tx_ready = 1'b0;
    push_frame();
    send_rx(8'h3F);
    for (int c = 0; c < 600; c++) begin
      if (!busy) break;
      if (hs_cnt == 4 && stall < 20) begin
        bus.tx_ready = 1'b0;
        stall++;
      end else begin
        bus.tx_ready = 1'($urandom_range(0, 1));
      end
      tick(1);
    end
    bus.tx_ready = 1'b1;
    check("bp_done", {31'd0, busy}, 32'd0);
    check("bp_stall_len", stall, 32'd20);
    check("bp_drained", exp_q.size(), 32'd0);
    check("bp_frames", {24'd0, frames_sent}, 32'd2);

    // snapshot and pending collapse
    do_reset();
    push_frame();
    send_rx(8'h3F);
    hunger = 4'd9;
    push_frame();
    hunger = 4'd3;
    for (int c = 0; c < 2 * LEN; c++) begin
      check("pend_busy", {31'd0, busy}, 32'd1);
      if (c == 2) begin hunger = 4'd9; second = ~second; end
      if (c == 3) second = ~second;
      if (c == 4) begin bus.rx_data = 8'h3F; bus.rx_valid = 1'b1; end
      if (c == 5) begin bus.rx_data = 8'h00; bus.rx_valid = 1'b0; end
      tick(1);
    end
    check("pend_idle", {31'd0, busy}, 32'd0);
    check("pend_frames", {24'd0, frames_sent}, 32'd2);
    check("pend_drained", exp_q.size(), 32'd0);
    tick(LEN);
    check("pend_no_third", {24'd0, frames_sent}, 32'd2);

    // reset in the middle of a frame
    push_frame();
    send_rx(8'h3F);
    tick(5);
    check("mid_valid", {31'd0, bus.tx_valid}, 32'd1);
    check("mid_byte5", {24'd0, bus.tx_data}, {24'd0, exp_byte(5)});
    reset = 1'b0;
    tick(1);
    check("abort_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_frames", {24'd0, frames_sent}, 32'd0);
    exp_q.delete();
    reset = 1'b1;
    tick(20);
    check("abort_quiet", {31'd0, busy}, 32'd0);
    check("abort_frames2", {24'd0, frames_sent}, 32'd0);

    // query-only instance
    b_valid_cnt = 0;
    b_got.delete();
    for (int i = 0; i < 5; i++) begin
      second_b = ~second_b;
      tick(2);
    end
    tick(5);
    check("ar0_second", b_valid_cnt, 32'd0);
    send_rx_b(8'h65);
    tick(15);
    check("ar0_nonquery", b_valid_cnt, 32'd0);
    send_rx_b(8'h3F);
    tick(LEN + 3);
    check("ar0_count", b_got.size(), LEN);
    for (int i = 0; i < LEN && i < b_got.size(); i++)
      check("ar0_byte", {24'd0, b_got[i]}, {24'd0, exp_byte(i)});
    check("ar0_frames", {24'd0, frames_sent_b}, 32'd1);

    // frame counter wrap
    do_reset();
    for (int f = 0; f < 256; f++) begin
      push_frame();
      send_rx(8'h3F);
      tick(LEN);
    end
    check("wrap_256", {24'd0, frames_sent}, 32'd0);
    push_frame();
    send_rx(8'h3F);
    tick(LEN);
    check("wrap_257", {24'd0, frames_sent}, 32'd1);

    check("final_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule

// File: doc/stats_reporter.md
Name: stats_reporter

Overview:
- Outbound side of the pet's UART command link: the stats block consumes command bytes, and this block emits ASCII status frames back to the host.
- Snapshots the six stat values and serializes them as a fixed-format ASCII frame.
- Drives a byte-wide valid/ready handshake into the UART transmitter.
- A frame is triggered by each toggle of the animation `second` signal, or by a host query byte arriving on the RX byte stream.

Parameters:
- QUERY_BYTE, 8'h3F ('?'): RX byte that requests an immediate frame.
- SOF_BYTE, 8'h53 ('S'): first byte of every frame.
- AUTO_REPORT, 1: 1 means a `second` toggle triggers a frame; 0 means only queries trigger frames.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- second  in  1  animation second flag; every toggle (either edge) is a periodic trigger
- hunger  in  4  stat value
- happiness  in  5  stat value
- health  in  4  stat value
- hygiene  in  4  stat value
- energy  in  4  stat value
- social  in  4  stat value
- rx_data  in  8  received UART byte
- rx_valid  in  1  rx_data is valid this cycle (single-cycle strobe)
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter accepts the byte
- busy  out  1  a frame is in progress
- frames_sent  out  8  count of completed frames, wraps 255 to 0

Behaviour:
- Reset (reset==0 at posedge):
  - tx_valid=0, tx_data=0, busy=0, frames_sent=0.
  - pending=0, state=IDLE, byte index=0.
  - second_q<=second, so no spurious trigger occurs after reset release.
  - Reset mid-frame aborts the frame immediately; no partial-frame completion.
- Trigger: `trig = (AUTO_REPORT && second!=second_q) || (rx_valid && rx_data==QUERY_BYTE)`. second_q is updated every cycle. A simultaneous second toggle and query produces one trigger.
- Frame bytes, in order:
  - SOF_BYTE.
  - hex(hunger).
  - hex({3'b0,happiness[4]}).
  - hex(happiness[3:0]).
  - hex(health), hex(hygiene), hex(energy), hex(social).
  - 8'h0D, 8'h0A.
  - Total 10 bytes (12 with the optional feature).
- hex(n): n<10 gives 8'h30+n; n>=10 gives 8'h41+(n-10), uppercase.
- State machine:
  - IDLE: on trig, latch all six stats into snapshot registers at that edge. Next cycle: state=SEND, index=0, tx_valid=1, tx_data=SOF_BYTE, busy=1.
  - SEND: tx_data and tx_valid are held stable until tx_valid&&tx_ready.
    - On a handshake of a non-last byte, index increments and the next byte is presented the following cycle with no bubble; tx_valid stays 1.
    - On a handshake of the last byte, frames_sent increments.
    - If pending=1, re-snapshot the stats at that edge, clear pending, and present SOF the next cycle, staying in SEND with index=0.
    - Otherwise go to IDLE with tx_valid=0 and busy=0.
- Frame content always comes from the snapshot; stat changes during a frame do not affect it.
- Trigger while in SEND sets pending. Multiple triggers collapse into one pending frame.
- A trigger in the same cycle as the last-byte handshake sets pending, and a new frame follows immediately.
- Non-query rx bytes are ignored.
- A tx_ready stall of any length is legal; no timeout.

Optional Feature:
- Macro: STATS_REPORT_CHECKSUM_EN.
- Defined:
  - The checksum C is the XOR of the 7 hex payload bytes (all bytes after SOF, before CR).
  - C is sent as hex(C[7:4]), hex(C[3:0]), inserted before CR LF.
  - Frame length becomes 12 bytes.
- Undefined: 10-byte frame, with no checksum logic present.

Test Plan:
- Single query:
  - Stimulus: hunger=3, happiness=5'h12, health=10, hygiene=0, energy=15, social=7; tx_ready=1; send rx byte 8'h3F.
  - Required: tx stream 53 33 31 32 41 30 46 37 0D 0A, on consecutive cycles starting 1 cycle after the query.
  - Required: busy=1 throughout; frames_sent=1.
  - With STATS_REPORT_CHECKSUM_EN: 53 33 31 32 41 30 46 37 33 30 0D 0A.
- Backpressure:
  - Stimulus: same stats; tx_ready toggles 0/1 randomly, with a 20-cycle stall on byte 4.
  - Required: identical byte sequence; tx_data stable while tx_valid=1 and tx_ready=0.
- Snapshot/pending:
  - Stimulus: change hunger 3 to 9 mid-frame, and toggle `second` twice plus send one query during the frame.
  - Required: first frame carries '3'.
  - Required: exactly one extra frame follows with no idle cycle, carrying '9'.
  - Required: frames_sent=2.
- AUTO_REPORT=0: toggle `second` 5 times → no tx_valid. Send rx byte 8'h65 → no frame. Send rx byte 8'h3F → one frame.
- Reset mid-frame: assert reset=0 during byte 5 → next cycle tx_valid=0, busy=0, frames_sent=0. After release with `second` static → no frame.
- Wrap: complete 256 frames → frames_sent=0; the 257th frame gives frames_sent=1.
